// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial pattern-detection controller.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Host-side bundle: configuration handshake, run control, serial stream and status.
interface seq_det_ctrl_if #(
  parameter int MAX_LEN = seq_det_pkg::DEF_MAX_LEN,
  parameter int LEN_W   = seq_det_pkg::DEF_LEN_W,
  parameter int CNT_W   = seq_det_pkg::DEF_CNT_W
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               din;
  logic               din_valid;
  logic               busy;
  logic               match;
  logic               done;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, din, din_valid,
    input  cfg_ready, busy, match, done, match_count
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, din, din_valid,
    output cfg_ready, busy, match, done, match_count
  );

endinterface

// File: rtl/seq_det_core.sv
// Detector datapath: bit history, fill level and the length-masked pattern compare.
module seq_det_core #(
  parameter int MAX_LEN = seq_det_pkg::DEF_MAX_LEN,
  parameter int LEN_W   = seq_det_pkg::DEF_LEN_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);

  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);

  // The oldest history bit only ever feeds the next compare, so it is never stored.
  logic [MAX_LEN-2:0] history_q;
  logic [MAX_LEN-1:0] history_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_next;

  always_comb begin
    history_next = {history_q, din};
    fill_next    = (fill_q == MAX_FILL) ? fill_q : fill_q + 1'b1;
    mask         = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
    hit = shift_en && (fill_next >= len) &&
          ((history_next & mask) == (pattern & mask));
  end

  // A non-overlapping hit consumes its bits by emptying the fill level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      history_q <= '0;
      fill_q    <= '0;
    end else if (clear) begin
      history_q <= '0;
      fill_q    <= '0;
    end else if (shift_en) begin
      history_q <= history_next[MAX_LEN-2:0];
      fill_q    <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run sequencer for the serial pattern detector: config capture, FSM, match
// counting and the registered match/done pulses.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic           clk,
  input logic           reset_n,
  seq_det_ctrl_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q, len_clamped;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;
  logic [CNT_W-1:0]   count_q, count_d, count_inc;
  logic               match_q, match_d;
  logic               done_q, done_d;
  logic               cfg_accept, clear, shift_en, hit;

  assign bus.cfg_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q == RUN);
  assign bus.match       = match_q;
  assign bus.done        = done_q;
  assign bus.match_count = count_q;

  assign cfg_accept = bus.cfg_valid && (state_q == IDLE);
  assign clear      = (state_q == IDLE) && bus.start;
  assign shift_en   = (state_q == RUN) && bus.din_valid && !bus.abort;

  always_comb begin
    if (bus.cfg_len == '0)
      len_clamped = LEN_W'(1);
    else if (bus.cfg_len > MAX_FILL)
      len_clamped = MAX_FILL;
    else
      len_clamped = bus.cfg_len;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      len_q     <= LEN_W'(1);
      overlap_q <= 1'b1;
      target_q  <= '0;
    end else if (cfg_accept) begin
      pattern_q <= bus.cfg_pattern;
      len_q     <= len_clamped;
      overlap_q <= bus.cfg_overlap;
      target_q  <= bus.cfg_target;
    end
  end

  seq_det_core #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .shift_en(shift_en),
    .din     (bus.din),
    .pattern (pattern_q),
    .len     (len_q),
    .overlap (overlap_q),
    .hit     (hit)
  );

  // Abort wins over a same-edge hit because shift_en is already gated by it.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    count_inc = count_q + 1'b1;
    match_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (shift_en && hit) begin
          match_d = 1'b1;
          if (target_q == '0) begin
            if (count_q != '1) count_d = count_inc;
          end else begin
            count_d = count_inc;
            if (count_inc == target_q) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

endmodule
